muldiv_sequencer: RTL and testbench

Iterative RV32M multiply/divide unit with its own control FSM. It sits beside the main ALU in the execute stage and is selected when the decoder flags an R-type instruction with `func7[0]=1` (the M-extension group). It runs shift-add multiplication and restoring division over a fixed number of cycles, and holds the pipeline with `stall` until the result is ready.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_datapath.sv | 121 ++++++++++++
 rtl/muldiv_sequencer.sv | 103 ++++++++++
 tb/tb_muldiv_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative RV32M multiply/divide unit.
//   - XLEN_DEFAULT : default operand/result width
//   - state_t      : sequencer FSM states
//   - F3_*         : M-extension func3 operation codes
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: shift-add multiplier / restoring divider on operand magnitudes,
// with sign correction and special-case resolution applied on the fix strobe.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   load            : capture func3, operand magnitudes and signs
//   step            : perform one multiply or divide iteration
//   fix             : sign-correct and register result
//   func3           : operation code (sampled on load)
//   op_a, op_b      : rs1 / rs2 values (sampled on load)
//   result          : final value, held until the next fix
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic            fix,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    // hi:lo is the product during multiply; hi = remainder, lo = quotient during divide.
    logic [XLEN-1:0] hi, lo, b_mag;
    logic [2:0]      f3_q;
    logic            neg_a, neg_b, ovf;

    // Operand conditioning at load.
    logic            signed_a, signed_b, in_neg_a, in_neg_b;
    logic [XLEN-1:0] in_mag_a, in_mag_b;

    assign signed_a = !(func3 == F3_MULHU || func3 == F3_DIVU || func3 == F3_REMU);
    assign signed_b = (func3 == F3_MUL || func3 == F3_MULH ||
                       func3 == F3_DIV || func3 == F3_REM);
    assign in_neg_a = signed_a & op_a[XLEN-1];
    assign in_neg_b = signed_b & op_b[XLEN-1];
    assign in_mag_a = in_neg_a ? -op_a : op_a;
    assign in_mag_b = in_neg_b ? -op_b : op_b;

    // One iteration of each algorithm.
    logic [XLEN:0] mul_sum, div_shift, div_diff;

    assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, b_mag} : '0);
    assign div_shift = {hi, lo[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, b_mag};

    // Sign correction and final selection.
    logic [2*XLEN-1:0] prod, prod_fixed;
    logic [XLEN-1:0]   quot_fixed, rem_fixed, fix_value;
    logic              div_zero;

    assign prod       = {hi, lo};
    assign prod_fixed = (neg_a ^ neg_b) ? -prod : prod;
    assign quot_fixed = (neg_a ^ neg_b) ? -lo : lo;
    // The remainder takes the dividend's sign; for divide-by-zero this reproduces opA.
    assign rem_fixed  = neg_a ? -hi : hi;
    assign div_zero   = (b_mag == '0);

    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        fix_value = quot_fixed;
        unique case (f3_q)
            F3_MUL:                       fix_value = prod_fixed[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_value = prod_fixed[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU: begin
                if (div_zero)  fix_value = '1;
                else if (ovf)  fix_value = MIN_NEG;
                else           fix_value = quot_fixed;
            end
            F3_REM, F3_REMU: begin
                if (div_zero)  fix_value = rem_fixed;
                else if (ovf)  fix_value = '0;
                else           fix_value = rem_fixed;
            end
            default:                      fix_value = quot_fixed;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            hi     <= '0;
            lo     <= '0;
            b_mag  <= '0;
            f3_q   <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            ovf    <= 1'b0;
            result <= '0;
        end else begin
            if (load) begin
                hi    <= '0;
                lo    <= in_mag_a;
                b_mag <= in_mag_b;
                f3_q  <= func3;
                neg_a <= in_neg_a;
                neg_b <= in_neg_b;
                // Only the signed divides can overflow.
                ovf   <= signed_b && (op_a == MIN_NEG) && (&op_b);
            end else if (step) begin
                if (f3_q[2]) begin
                    hi <= div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
                    lo <= {lo[XLEN-2:0], ~div_diff[XLEN]};
                end else begin
                    hi <= mul_sum[XLEN:1];
                    lo <= {mul_sum[0], lo[XLEN-1:1]};
                end
            end
            if (fix) begin
                result <= fix_value;
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: RV32M multiply/divide unit with control FSM. Holds the
// pipeline via stall until the fixed-latency (XLEN+2 cycle) result is ready.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   start            : M-type instruction in execute, held until done
//   func3            : operation code
//   opA, opB         : rs1 / rs2, sampled at accept
//   kill             : pipeline flush, aborts any operation
//   stall            : freeze PC and IF/ID/EX registers
//   busy             : FSM not in IDLE
//   done             : one-cycle pulse, result valid
//   result           : final value, held until the next operation completes
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    input  logic            kill,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    state_t          state, state_next;
    logic [CW-1:0]   count, count_next;
    logic            load, step, fix;

    always_comb begin
        state_next = state;
        count_next = count;
        load       = 1'b0;
        step       = 1'b0;
        fix        = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = CALC;
                    count_next = CW'(XLEN - 1);
                    load       = 1'b1;
                end
            end
            CALC: begin
                step       = 1'b1;
                count_next = count - 1'b1;
                // The edge that sees 0 still performs the last iteration.
                if (count == '0) begin
                    state_next = FIX;
                    count_next = '0;
                end
            end
            FIX: begin
                fix        = 1'b1;
                state_next = DONE;
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Flush overrides everything; dropping fix leaves result untouched.
        if (kill) begin
            state_next = IDLE;
            count_next = '0;
            load       = 1'b0;
            step       = 1'b0;
            fix        = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    assign busy  = (state != IDLE);
    assign done  = (state == DONE) & ~kill;
    assign stall = ~reset & (((state == IDLE) & start) | (state == CALC) | (state == FIX));

    muldiv_datapath #(.XLEN(XLEN)) u_datapath (
        .clk    (clk),
        .rst    (reset),
        .load   (load),
        .step   (step),
        .fix    (fix),
        .func3  (func3),
        .op_a   (opA),
        .op_b   (opB),
        .result (result)
    );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: table-driven and randomized checks of muldiv_sequencer
// against an arithmetic reference model, plus kill/reset/back-to-back sequences.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int XLEN = 32;
    localparam int LAT  = XLEN + 2;

    logic            clk = 1'b0;
    logic            reset, start, kill;
    logic [2:0]      func3;
    logic [XLEN-1:0] opA, opB;
    logic            stall, busy, done;
    logic [XLEN-1:0] result;

    int passed = 0;
    int total  = 0;
    int cycle  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    muldiv_sequencer #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .func3  (func3),
        .opA    (opA),
        .opB    (opB),
        .kill   (kill),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference model: plain 64-bit arithmetic following the RV32M rules.
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub, p, q;
        logic [63:0] pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (f3)
            F3_MUL:    begin p = sa * sb; return p[31:0]; end
            F3_MULH:   begin p = sa * sb; return p[63:32]; end
            F3_MULHSU: begin p = sa * ub; return p[63:32]; end
            F3_MULHU:  begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            F3_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                q = sa / sb; return q[31:0];
            end
            F3_DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                q = ua / ub; return q[31:0];
            end
            F3_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                q = sa % sb; return q[31:0];
            end
            default: begin
                if (b == 0) return a;
                q = ua % ub; return q[31:0];
            end
        endcase
    endfunction

    // Issue one operation; report result, cycles to done, stall cycles and stall in the done cycle.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int stalls,
                          output logic stall_done, output bit ok);
        @(negedge clk);
        func3 = f3; opA = a; opB = b; start = 1'b1;
        #1;
        lat = 0; stalls = 0; ok = 0; res = '0; stall_done = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (stall) stalls++;
            @(posedge clk);
            lat++;
            if (lat == 1) begin
                #1;
                opA = $urandom;
                opB = $urandom;
            end
            @(negedge clk);
            if (done) begin
                ok = 1; res = result; stall_done = stall;
                break;
            end
        end
        start = 1'b0;
        if (!ok) check("op_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic [31:0] res;
        logic        sd;
        int          lat, stalls, n_done, t1, t2;
        bit          ok;

        vecs[0]  = '{"mul_7_m3",     F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{"mulhu_ff_ff",  F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[2]  = '{"mulh_ff_ff",   F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[3]  = '{"mulhsu_ff_ff", F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4]  = '{"div_m7_2",     F3_DIV,    32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD};
        vecs[5]  = '{"rem_m7_2",     F3_REM,    32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF};
        vecs[6]  = '{"divu_100_7",   F3_DIVU,   32'd100,        32'd7,          32'd14};
        vecs[7]  = '{"remu_100_7",   F3_REMU,   32'd100,        32'd7,          32'd2};
        vecs[8]  = '{"div_5_0",      F3_DIV,    32'd5,          32'd0,          32'hFFFF_FFFF};
        vecs[9]  = '{"rem_5_0",      F3_REM,    32'd5,          32'd0,          32'd5};
        vecs[10] = '{"div_ovf",      F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[11] = '{"rem_ovf",      F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[12] = '{"div_m5_0",     F3_DIV,    32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFF};
        vecs[13] = '{"rem_m5_0",     F3_REM,    32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFB};
        vecs[14] = '{"divu_min_ff",  F3_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[15] = '{"remu_min_ff",  F3_REMU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};

        // Reset state; start high during reset must not raise stall.
        reset = 1'b1; start = 1'b1; kill = 1'b0; func3 = '0; opA = '0; opB = '0;
        #12;
        check("rst_stall",  32'(stall),  32'd0);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_result", result,      32'd0);
        @(negedge clk);
        start = 1'b0; reset = 1'b0;

        // Directed table.
        foreach (vecs[i]) begin
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, res, lat, stalls, sd, ok);
            if (ok) begin
                check({vecs[i].name, "_result"}, res, vecs[i].exp);
                check({vecs[i].name, "_latency"}, 32'(lat), 32'(LAT));
                check({vecs[i].name, "_stall_cycles"}, 32'(stalls), 32'(LAT));
                check({vecs[i].name, "_stall_in_done"}, 32'(sd), 32'd0);
            end
        end

        // Randomized operations against the model.
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 20));
                default: b = 32'($urandom);
            endcase
            run_op(f3, a, b, res, lat, stalls, sd, ok);
            if (ok) begin
                check($sformatf("rand%0d_f3_%0d_result", i, f3), res, model(f3, a, b));
                check($sformatf("rand%0d_latency", i), 32'(lat), 32'(LAT));
            end
        end

        // Kill mid-divide: result keeps prior value, no done pulse.
        run_op(F3_DIVU, 32'd100, 32'd7, res, lat, stalls, sd, ok);
        @(negedge clk);
        func3 = F3_DIV; opA = 32'd1000; opB = 32'd3; start = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        kill = 1'b1; start = 1'b0;
        @(negedge clk);
        check("kill_busy",   32'(busy),  32'd0);
        check("kill_stall",  32'(stall), 32'd0);
        check("kill_result", result,     32'd14);
        kill = 1'b0;
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("kill_no_done", 32'(n_done), 32'd0);
        run_op(F3_DIV, 32'd1000, 32'd3, res, lat, stalls, sd, ok);
        if (ok) begin
            check("after_kill_result",  res,      32'd333);
            check("after_kill_latency", 32'(lat), 32'(LAT));
        end

        // Kill together with start in IDLE: no accept.
        @(negedge clk);
        start = 1'b1; kill = 1'b1; func3 = F3_MUL;
        @(negedge clk);
        check("kill_start_busy", 32'(busy), 32'd0);
        start = 1'b0; kill = 1'b0;

        // Asynchronous reset mid-operation.
        @(negedge clk);
        func3 = F3_MUL; opA = 32'd9; opB = 32'd9; start = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_busy",   32'(busy),  32'd0);
        check("mid_rst_stall",  32'(stall), 32'd0);
        check("mid_rst_done",   32'(done),  32'd0);
        check("mid_rst_result", result,     32'd0);
        @(negedge clk);
        start = 1'b0; reset = 1'b0;

        // Back-to-back MULs with start held through DONE.
        @(negedge clk);
        func3 = F3_MUL; opA = 32'd7; opB = 32'hFFFF_FFFD; start = 1'b1;
        ok = 0; t1 = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (done) begin ok = 1; t1 = cycle; break; end
        end
        if (!ok) check("b2b_first_timeout", 32'd0, 32'd1);
        else begin
            check("b2b_first_result", result, 32'hFFFF_FFEB);
            opA = 32'd6; opB = 32'd9;
            @(negedge clk);
            check("b2b_no_reaccept_in_done", 32'(busy), 32'd0);
            ok = 0; t2 = 0;
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                if (done) begin ok = 1; t2 = cycle; break; end
            end
            if (!ok) check("b2b_second_timeout", 32'd0, 32'd1);
            else begin
                check("b2b_second_result", result, 32'd54);
                check("b2b_interval", 32'(t2 - t1), 32'(XLEN + 3));
            end
        end
        start = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
